// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares one UART transmitter among N_REQ byte
// producers. One byte is accepted per grant, a single-cycle start pulse is
// issued with stable data, and the next grant waits for the frame-done
// pulse or for the watchdog to give up on it.
module uart_tx_arbiter #(
    parameter int NB_DATA        = 8,
    parameter int N_REQ          = 4,
    parameter int LEN_PTR        = $clog2(N_REQ),
    parameter int TIMEOUT_CYCLES = 65536,
    parameter int LEN_TMO        = $clog2(TIMEOUT_CYCLES)
) (
    input  logic                     i_clock,
    input  logic                     i_reset,
    input  logic [N_REQ-1:0]         i_req_valid,
    input  logic [N_REQ*NB_DATA-1:0] i_req_data,
    output logic [N_REQ-1:0]         o_req_ready,
    output logic                     o_tx_start,
    output logic [NB_DATA-1:0]       o_tx_data,
    input  logic                     i_tx_done,
    output logic                     o_busy,
    output logic [LEN_PTR-1:0]       o_grant_id,
    output logic                     o_timeout
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'b001,
        ST_START     = 3'b010,
        ST_WAIT_DONE = 3'b100
    } state_e;

    localparam logic [LEN_PTR-1:0] PTR_LAST = LEN_PTR'(N_REQ - 1);
    localparam logic [LEN_TMO-1:0] TMO_LAST = LEN_TMO'(TIMEOUT_CYCLES - 1);

    state_e               state_q, state_d;
    logic [LEN_PTR-1:0]   ptr_q, ptr_d;
    logic [NB_DATA-1:0]   tx_data_q, tx_data_d;
    logic [LEN_PTR-1:0]   grant_id_q, grant_id_d;
    logic [LEN_TMO-1:0]   wdog_q, wdog_d;
    logic                 timeout_q, timeout_d;

    logic                 any_valid;
    logic                 found_hi;
    logic [LEN_PTR-1:0]   winner_hi;
    logic                 found_lo;
    logic [LEN_PTR-1:0]   winner_lo;
    logic [LEN_PTR-1:0]   winner;
    logic [NB_DATA-1:0]   winner_data;
    logic                 transfer;

    // Round-robin winner: lowest valid index at or above the pointer,
    // otherwise the lowest valid index overall (the wrapped part of the search).
    always_comb begin
        found_hi  = 1'b0;
        winner_hi = '0;
        found_lo  = 1'b0;
        winner_lo = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (!found_hi && i_req_valid[k] && (LEN_PTR'(k) >= ptr_q)) begin
                found_hi  = 1'b1;
                winner_hi = LEN_PTR'(k);
            end
            if (!found_lo && i_req_valid[k]) begin
                found_lo  = 1'b1;
                winner_lo = LEN_PTR'(k);
            end
        end
        winner    = found_hi ? winner_hi : winner_lo;
        any_valid = found_lo;
    end

    // Byte offered by the current winner.
    always_comb begin
        winner_data = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (LEN_PTR'(k) == winner) begin
                winner_data = i_req_data[k*NB_DATA +: NB_DATA];
            end
        end
    end

    // One-hot acceptance, only in IDLE with a pending request and never in reset.
    always_comb begin
        o_req_ready = '0;
        transfer    = (state_q == ST_IDLE) && any_valid && !i_reset;
        if (transfer) begin
            o_req_ready[winner] = 1'b1;
        end
    end

    // Next-state, pointer, data latch and watchdog logic.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        tx_data_d  = tx_data_q;
        grant_id_d = grant_id_q;
        wdog_d     = wdog_q;
        timeout_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    tx_data_d  = winner_data;
                    grant_id_d = winner;
                    ptr_d      = (winner == PTR_LAST) ? '0 : winner + 1'b1;
                    state_d    = ST_START;
                end
            end
            ST_START: begin
                wdog_d  = '0;
                state_d = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                // Done has priority over the terminal watchdog count.
                if (i_tx_done) begin
                    wdog_d  = '0;
                    state_d = ST_IDLE;
                end else if (wdog_q == TMO_LAST) begin
                    wdog_d    = '0;
                    timeout_d = 1'b1;
                    state_d   = ST_IDLE;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                ptr_d      = '0;
                tx_data_d  = '0;
                grant_id_d = '0;
                wdog_d     = '0;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-high reset.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            tx_data_q  <= '0;
            grant_id_q <= '0;
            wdog_q     <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            tx_data_q  <= tx_data_d;
            grant_id_q <= grant_id_d;
            wdog_q     <= wdog_d;
            timeout_q  <= timeout_d;
        end
    end

    assign o_tx_start = (state_q == ST_START);
    assign o_busy     = (state_q != ST_IDLE);
    assign o_tx_data  = tx_data_q;
    assign o_grant_id = grant_id_q;
    assign o_timeout  = timeout_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter. Two instances share stimulus: one with
// a long watchdog for normal traffic, one with a 16-cycle watchdog for the
// timeout cases. A scoreboard of expected {grant, byte} pairs is checked on
// every start pulse of the instance currently under observation.
module tb_uart_tx_arbiter;

    localparam int NB = 8;
    localparam int NR = 4;
    localparam int LP = 2;

    logic              i_clock;
    logic              i_reset;
    logic [NR-1:0]     i_req_valid;
    logic [NR*NB-1:0]  i_req_data;
    logic              i_tx_done;

    logic [NR-1:0]     ready_a, ready_b;
    logic              start_a, start_b;
    logic [NB-1:0]     data_a, data_b;
    logic              busy_a, busy_b;
    logic [LP-1:0]     grant_a, grant_b;
    logic              tmo_a, tmo_b;

    bit                sel;
    logic [NR-1:0]     v_ready;
    logic              v_start;
    logic [NB-1:0]     v_data;
    logic              v_busy;
    logic [LP-1:0]     v_grant;
    logic              v_timeout;

    int                errors;
    int                checks;
    logic [15:0]       exp_q[$];
    logic [NR-1:0]     rdy_seen;
    logic [NR-1:0]     hold;

    uart_tx_arbiter #(.NB_DATA(NB), .N_REQ(NR), .TIMEOUT_CYCLES(1024)) u_dut_a (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .o_req_ready (ready_a),
        .o_tx_start  (start_a),
        .o_tx_data   (data_a),
        .i_tx_done   (i_tx_done),
        .o_busy      (busy_a),
        .o_grant_id  (grant_a),
        .o_timeout   (tmo_a)
    );

    uart_tx_arbiter #(.NB_DATA(NB), .N_REQ(NR), .TIMEOUT_CYCLES(16)) u_dut_b (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_req_valid (i_req_valid),
        .i_req_data  (i_req_data),
        .o_req_ready (ready_b),
        .o_tx_start  (start_b),
        .o_tx_data   (data_b),
        .i_tx_done   (i_tx_done),
        .o_busy      (busy_b),
        .o_grant_id  (grant_b),
        .o_timeout   (tmo_b)
    );

    assign v_ready   = sel ? ready_b : ready_a;
    assign v_start   = sel ? start_b : start_a;
    assign v_data    = sel ? data_b  : data_a;
    assign v_busy    = sel ? busy_b  : busy_a;
    assign v_grant   = sel ? grant_b : grant_a;
    assign v_timeout = sel ? tmo_b   : tmo_a;

    initial i_clock = 1'b0;
    always #5 i_clock = ~i_clock;

    initial begin
        #200000;
        $display("FAIL global_time_limit: observed no finish, required finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    // One clock: scoreboard check at the falling edge, then requesters drop
    // valid for any byte accepted on the rising edge (unless held), done clears.
    task automatic cyc();
        @(negedge i_clock);
        rdy_seen = v_ready;
        if (!i_reset && v_start === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_start: observed grant %0d data %0h, required no start",
                       v_grant, v_data);
            end else begin
                check("start_grant_data", {6'b0, v_grant, v_data}, exp_q.pop_front());
            end
        end
        @(posedge i_clock);
        #1;
        i_req_valid = i_req_valid & ~(rdy_seen & ~hold);
        i_tx_done   = 1'b0;
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_data(input int k, input logic [7:0] v);
        i_req_data[k*NB +: NB] = v;
    endtask

    task automatic push(input int id, input logic [7:0] v);
        exp_q.push_back({8'(id), v});
    endtask

    task automatic wait_start(input int budget);
        int n;
        n = 0;
        while (v_start !== 1'b1 && n < budget) begin
            cyc();
            n++;
        end
        check("start_seen", {31'b0, v_start}, 32'd1);
    endtask

    task automatic do_reset();
        i_reset     = 1'b1;
        i_req_valid = '0;
        hold        = '0;
        i_tx_done   = 1'b0;
        cyc();
        cyc();
        check("rst_busy",    {31'b0, v_busy},    32'd0);
        check("rst_start",   {31'b0, v_start},   32'd0);
        check("rst_ready",   {28'b0, v_ready},   32'd0);
        check("rst_data",    {24'b0, v_data},    32'd0);
        check("rst_grant",   {30'b0, v_grant},   32'd0);
        check("rst_timeout", {31'b0, v_timeout}, 32'd0);
        i_reset = 1'b0;
        settle();
    endtask

    initial begin
        int busy_low;
        int tmo_hi;
        errors      = 0;
        checks      = 0;
        sel         = 1'b0;
        i_reset     = 1'b1;
        i_req_valid = '0;
        i_req_data  = '0;
        i_tx_done   = 1'b0;
        hold        = '0;
        rdy_seen    = '0;

        // Single byte from requester 2, done 160 cycles after start.
        do_reset();
        set_data(2, 8'hA5);
        i_req_valid = 4'b0100;
        push(2, 8'hA5);
        settle();
        check("p1_ready_idle", {28'b0, v_ready}, 32'h4);
        check("p1_busy_idle",  {31'b0, v_busy},  32'd0);
        cyc();
        check("p1_start",   {31'b0, v_start}, 32'd1);
        check("p1_data",    {24'b0, v_data},  32'hA5);
        check("p1_grant",   {30'b0, v_grant}, 32'd2);
        check("p1_ready_0", {28'b0, v_ready}, 32'd0);
        busy_low = 0;
        for (int i = 0; i < 159; i++) begin
            cyc();
            if (v_busy !== 1'b1) busy_low++;
        end
        check("p1_busy_held", busy_low, 32'd0);
        check("p1_data_held", {24'b0, v_data}, 32'hA5);
        i_tx_done = 1'b1;
        cyc();
        check("p1_idle_after_done", {31'b0, v_busy}, 32'd0);

        // Contention: all four requesters, served in index order.
        do_reset();
        for (int k = 0; k < NR; k++) begin
            set_data(k, 8'(16 + k));
            push(k, 8'(16 + k));
        end
        i_req_valid = 4'b1111;
        settle();
        check("p2_ready_first", {28'b0, v_ready}, 32'h1);
        for (int k = 0; k < NR; k++) begin
            wait_start(8);
            repeat (19) cyc();
            i_tx_done = 1'b1;
            cyc();
        end
        check("p2_queue_empty", exp_q.size(), 32'd0);
        check("p2_last_grant",  {30'b0, v_grant}, 32'd3);
        for (int k = 0; k < NR; k++) set_data(k, 8'(32 + k));
        i_req_valid = 4'b1111;
        push(0, 8'h20);
        wait_start(4);
        i_req_valid = '0;
        check("p2_ptr_wrapped", {30'b0, v_grant}, 32'd0);
        repeat (3) cyc();
        i_tx_done = 1'b1;
        cyc();

        // Fairness: requester 0 always valid, requester 3 joins after first grant.
        do_reset();
        set_data(0, 8'h30);
        set_data(3, 8'h33);
        hold        = 4'b0001;
        i_req_valid = 4'b0001;
        push(0, 8'h30);
        push(3, 8'h33);
        push(0, 8'h30);
        push(3, 8'h33);
        settle();
        for (int k = 0; k < 4; k++) begin
            wait_start(8);
            if (k == 3) begin
                hold        = '0;
                i_req_valid = '0;
            end else begin
                i_req_valid[3] = 1'b1;
            end
            repeat (4) cyc();
            i_tx_done = 1'b1;
            cyc();
        end
        check("p3_queue_empty", exp_q.size(), 32'd0);

        // Timeout on the 16-cycle instance.
        sel = 1'b1;
        do_reset();
        set_data(1, 8'h41);
        set_data(2, 8'h42);
        set_data(0, 8'h40);
        i_req_valid = 4'b0010;
        push(1, 8'h41);
        settle();
        wait_start(4);
        i_req_valid = 4'b0101;
        tmo_hi = 0;
        for (int n = 1; n <= 16; n++) begin
            cyc();
            if (v_timeout !== 1'b0) tmo_hi++;
        end
        check("p4_no_early_timeout", tmo_hi, 32'd0);
        check("p4_busy_terminal",    {31'b0, v_busy}, 32'd1);
        cyc();
        check("p4_timeout_pulse", {31'b0, v_timeout}, 32'd1);
        check("p4_idle",          {31'b0, v_busy},    32'd0);
        check("p4_next_ready",    {28'b0, v_ready},   32'h4);
        i_req_valid[0] = 1'b0;
        push(2, 8'h42);
        cyc();
        check("p4_timeout_one_cycle", {31'b0, v_timeout}, 32'd0);
        check("p4_next_start",        {31'b0, v_start},   32'd1);

        // Done arriving on the terminal watchdog cycle wins over the timeout.
        tmo_hi = 0;
        for (int m = 1; m <= 16; m++) begin
            cyc();
            if (v_timeout !== 1'b0) tmo_hi++;
        end
        check("p5_no_timeout_before", tmo_hi, 32'd0);
        i_tx_done = 1'b1;
        cyc();
        check("p5_done_wins_tmo",  {31'b0, v_timeout}, 32'd0);
        check("p5_done_wins_idle", {31'b0, v_busy},    32'd0);
        cyc();
        check("p5_no_late_timeout", {31'b0, v_timeout}, 32'd0);
        check("p5_queue_empty", exp_q.size(), 32'd0);

        // Done pulses in IDLE and START are ignored.
        sel = 1'b0;
        do_reset();
        i_tx_done = 1'b1;
        cyc();
        check("p5_done_idle_busy",  {31'b0, v_busy},  32'd0);
        check("p5_done_idle_start", {31'b0, v_start}, 32'd0);
        set_data(1, 8'h51);
        i_req_valid = 4'b0010;
        push(1, 8'h51);
        settle();
        cyc();
        check("p5_start", {31'b0, v_start}, 32'd1);
        i_tx_done = 1'b1;
        cyc();
        check("p5_done_start_ignored", {31'b0, v_busy}, 32'd1);
        cyc();
        check("p5_still_waiting", {31'b0, v_busy}, 32'd1);
        i_tx_done = 1'b1;
        cyc();
        check("p5_done_wait_idle", {31'b0, v_busy}, 32'd0);

        // Reset asserted in WAIT_DONE.
        do_reset();
        set_data(2, 8'h62);
        i_req_valid = 4'b0100;
        push(2, 8'h62);
        settle();
        wait_start(4);
        repeat (3) cyc();
        check("p6_in_wait", {31'b0, v_busy}, 32'd1);
        i_reset = 1'b1;
        #1;
        check("p6_rst_busy",    {31'b0, v_busy},    32'd0);
        check("p6_rst_start",   {31'b0, v_start},   32'd0);
        check("p6_rst_data",    {24'b0, v_data},    32'd0);
        check("p6_rst_grant",   {30'b0, v_grant},   32'd0);
        check("p6_rst_timeout", {31'b0, v_timeout}, 32'd0);
        set_data(1, 8'h61);
        set_data(3, 8'h63);
        i_req_valid = 4'b1010;
        settle();
        check("p6_rst_ready", {28'b0, v_ready}, 32'd0);
        cyc();
        cyc();
        i_reset = 1'b0;
        settle();
        check("p6_first_ready", {28'b0, v_ready}, 32'h2);
        push(1, 8'h61);
        wait_start(4);
        i_req_valid = '0;
        repeat (3) cyc();
        i_tx_done = 1'b1;
        cyc();
        cyc();
        check("final_queue_empty", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter sharing one UART transmitter among N_REQ byte producers, e.g. ALU result path, status reporter and debug echo.
- Accepts one byte per grant over a valid/ready handshake and issues a single-cycle start with stable data to the transmitter.
- Waits for the transmitter's frame-done pulse before granting again.
- A watchdog recovers the arbiter if the done pulse never arrives.

Parameters:
- NB_DATA, 8, width of one transmitted byte; must match the transmitter's data width.
- N_REQ, 4, number of requesters; must be at least 2.
- LEN_PTR, $clog2(N_REQ), width of the requester index.
- TIMEOUT_CYCLES, 65536, clock cycles allowed in WAIT_DONE before abort; must exceed one full frame time.
- LEN_TMO, $clog2(TIMEOUT_CYCLES), width of the watchdog counter.

Ports:
- i_clock  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_req_valid  in  N_REQ  bit k set: requester k holds a byte.
- i_req_data  in  N_REQ*NB_DATA  requester k's byte is at bits [k*NB_DATA +: NB_DATA].
- o_req_ready  out  N_REQ  one-hot acceptance; combinational.
- o_tx_start  out  1  one-cycle start pulse to the transmitter.
- o_tx_data  out  NB_DATA  registered byte to the transmitter.
- i_tx_done  in  1  one-cycle pulse from the transmitter at the end of the stop bit.
- o_busy  out  1  high in any state other than IDLE.
- o_grant_id  out  LEN_PTR  index of the last granted requester.
- o_timeout  out  1  one-cycle pulse when the watchdog aborts a frame.

Behaviour:
- Reset values:
  - state IDLE, priority pointer 0.
  - o_tx_data 0, o_grant_id 0, o_timeout 0.
  - watchdog counter 0.
  - o_tx_start 0, o_busy 0, o_req_ready all 0.
- States, one-hot: IDLE, START, WAIT_DONE.
- IDLE:
  - Winner w is the first index with valid set, searching ptr, ptr+1, ..., wrapping modulo N_REQ.
  - o_req_ready has only bit w set, and only while in IDLE with any valid bit set; all 0 otherwise.
  - A transfer happens on the clock edge where valid[w] and ready[w] are both high. On that edge:
    - o_tx_data takes requester w's byte.
    - o_grant_id takes w.
    - ptr takes (w+1) mod N_REQ; when w = N_REQ-1, ptr becomes 0.
    - state goes to START.
  - No valid bits set: stay in IDLE.
- START:
  - o_tx_start = 1 for exactly this cycle; o_tx_data stays stable.
  - Clear the watchdog and go to WAIT_DONE unconditionally.
  - i_tx_done is ignored in this cycle.
- WAIT_DONE:
  - o_tx_data is held until the state leaves WAIT_DONE.
  - i_tx_done = 1: go to IDLE, clear the watchdog.
  - Otherwise, watchdog == TIMEOUT_CYCLES-1: pulse o_timeout (registered, high the next cycle only), go to IDLE.
  - Otherwise, increment the watchdog.
  - i_tx_done and the terminal watchdog count in the same cycle: done wins, no timeout pulse.
- Latency and throughput:
  - Transfer edge to o_tx_start high: 1 cycle.
  - i_tx_done in IDLE or START is ignored.
  - After done, the earliest next transfer happens in the IDLE cycle that follows.
  - Minimum gap: done edge, then the IDLE cycle, then START.
- Fairness:
  - A requester that holds valid continuously is served within N_REQ grants.
  - A requester that drops valid before it is granted loses nothing and is not tracked.
- Any state in an illegal encoding returns to IDLE with the pointer, watchdog and outputs at their reset values.
- Reset asserted mid-frame (START or WAIT_DONE):
  - Return immediately to reset values.
  - No spurious o_tx_start; the byte in flight is dropped.
  - The transmitter is reset by the same i_reset.

Test Plan:
- Single byte: after reset, valid[2]=1 with data 0xA5:
  - ready[2] high in the IDLE cycle.
  - Next cycle o_tx_start=1 and o_tx_data=0xA5; o_grant_id=2.
  - o_busy stays high until a done pulse injected 160 cycles later, then IDLE.
- Contention:
  - All four valid with data 0x10..0x13 held until accepted; done returned 20 cycles after each start.
  - Start pulses carry 0x10, 0x11, 0x12, 0x13 in that order; the pointer wraps to 0.
- Fairness:
  - valid[0] stuck high, valid[3] raised after the first grant.
  - Grant order 0, 3, 0, 3; requester 3 is never skipped.
- Timeout, TIMEOUT_CYCLES=16:
  - Grant requester 1, never pulse done.
  - o_timeout high exactly one cycle, 16 cycles after START; state returns to IDLE; the next grant goes to requester 2 if it is valid.
- Done races:
  - i_tx_done pulsed in IDLE and in START: ignored.
  - i_tx_done on the terminal watchdog cycle: no o_timeout, normal return to IDLE.
- Reset mid-frame:
  - Assert i_reset in WAIT_DONE.
  - All outputs return to reset values within the cycle; o_grant_id=0; the first grant after release goes to the lowest valid index from 0.
